seg_share_ctrl: RTL and testbench
=================================

Name: seg_share_ctrl

Overview:
- Time-slice scheduler that shares the 8-digit seven-segment display bank between NREQ requesters.
- Each requester presents a 32-bit hex value: 8 nibbles, nibble k maps to digit k.
- Ownership rotates round-robin, with a programmable dwell per slice and a one-cycle blank gap at each handover.
- Drives the o_seg0..o_seg7 board pins directly, and tells each requester when it owns the display.

Parameters:
- NREQ, 3, number of requesters, 2..8.
- SLICE_CYCLES, 5000000, minimum clock cycles an owner keeps the display while others wait; must be ≥2.
- CNT_W, 32, slice counter width; must hold SLICE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- i_req  input  NREQ  bit i = requester i wants the display (level).
- i_data  input  NREQ*32  requester i value in bits [32i+31:32i]; nibble k → digit k.
- i_dp  input  NREQ*8  requester i decimal points, bit k → digit k, 1 = lit.
- o_grant  output  NREQ  one-hot current owner, all-zero when none.
- o_seg0..o_seg7  output  8 each  active-low segments; bit7..bit1 = a..g, bit0 = dp.

Behaviour:
- Encoding: active-high pattern inverted at the pin.
  - Hex table, active-high a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Blank = all pins 8'hFF.
- All outputs registered. Reset values: o_grant=0, all o_seg*=8'hFF, state=IDLE, cnt=0, rr_ptr=0.
- States: IDLE, SHOW, GAP.
- IDLE:
  - o_grant=0, segs blank.
  - If i_req≠0, pick the first set bit scanning upward from rr_ptr with wrap → SHOW, owner set, cnt=0.
  - o_grant and segs reflect the new owner on that same edge.
- SHOW:
  - Every cycle, segs reload from the owner's live i_data/i_dp. Latency is 1 cycle from input to pin.
  - cnt increments and saturates at SLICE_CYCLES-1.
  - If the owner's i_req=0 → GAP, regardless of cnt.
  - Else if cnt==SLICE_CYCLES-1 and any other i_req bit is set → GAP.
  - Else stay. A sole requester holds the display indefinitely.
- GAP (exactly 1 cycle):
  - o_grant=0, segs blank, rr_ptr=owner+1 mod NREQ.
  - Next edge: if i_req≠0, arbitrate from the new rr_ptr → SHOW with cnt=0; else → IDLE.
  - A requester that just lost ownership may win again only if no other bit is set.
- Simultaneous events:
  - Owner drop and slice expiry in the same cycle → single GAP.
  - New requests arriving during GAP are visible to that arbitration.
- Reset mid-operation: returns to the reset values on the next edge; any in-progress slice is discarded.
- i_data/i_dp of non-owners are ignored. No combinational path from inputs to outputs.

Optional Feature:
- SEG_SHARE_OWNER_ID_EN defined: in SHOW, o_seg7 shows the owner index as a hex digit instead of nibble 7, with dp lit.
- Undefined: o_seg7 shows nibble 7 of the owner's data.
- o_grant and timing are identical either way.

Decomposition:
- Package seg_share_pkg:
  - state enum IDLE/SHOW/GAP;
  - 16-entry hex-to-segment constant table;
  - SEG_BLANK = 8'hFF;
  - function hex2seg(nibble, dp) returning the active-low byte.
- Sub-module seg_share_rr_pick: combinational round-robin picker. Inputs req[NREQ] and ptr. Outputs one-hot grant and valid. Instantiated once.

Test Plan:
- Reset, then idle with i_req=0 for 10 cycles → o_grant=0, all o_seg*=8'hFF throughout.
- SLICE_CYCLES=4. Requester 0 alone, i_data=32'h76543210 → grant=001 one edge after request. o_seg0=~8'b11111100, o_seg7=~8'b11100000. Held 20+ cycles with no GAP.
- SLICE_CYCLES=4. Requesters 0 and 1 both held high → owner0 4 cycles, GAP 1 cycle blank, owner1 4 cycles, GAP, owner0. Check the period is 10 cycles.
- Owner 1 drops i_req at cnt=1 while requester 2 waits → next edge GAP, following edge grant=100. Requester 0 asserted simultaneously is not chosen; rr_ptr=2.
- i_dp=8'h01, owner data nibble 0 = 4'hA → o_seg0 = ~8'b11101111. Change nibble 0 to 4'hF → o_seg0 = ~8'b10001111 one cycle later.
- Assert rst during SHOW at cnt=2 → next edge grant=0, segs blank. After release with requester 1 only → grant=010, cnt restarts at 0.

Source files
------------

// File: rtl/seg_share_pkg.sv
// Shared types and segment encoding for the seven-segment display sharing controller.
package seg_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-high a..g patterns, a in the MSB
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic logic [7:0] hex2seg(input logic [3:0] nib, input logic dp);
    return ~{HEX_SEG[nib], dp};
  endfunction

endpackage

// File: rtl/seg_share_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module seg_share_rr_pick
  import seg_share_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic             valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = (int'(ptr) + off) % NREQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_share_ctrl.sv
// Round-robin time-slice owner of the 8-digit seven-segment bank with a blank handover gap.
// Optional: define SEG_SHARE_OWNER_ID_EN to show the owner index on digit 7.
module seg_share_ctrl
  import seg_share_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int SLICE_CYCLES = 5000000,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*32-1:0] i_data,
  input  logic [NREQ*8-1:0] i_dp,
  output logic [NREQ-1:0]   o_grant,
  output logic [7:0]        o_seg0,
  output logic [7:0]        o_seg1,
  output logic [7:0]        o_seg2,
  output logic [7:0]        o_seg3,
  output logic [7:0]        o_seg4,
  output logic [7:0]        o_seg5,
  output logic [7:0]        o_seg6,
  output logic [7:0]        o_seg7
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLICE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [7:0]         seg_q [8];
  logic [7:0]         seg_d [8];

  logic [NREQ-1:0]    pick_gnt;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   sel;
  logic               show;
  logic               others;

  seg_share_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (pick_gnt),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    show    = 1'b0;
    sel     = owner_q;
    // grant_q is the owner's one-hot while showing, so this flags any waiting requester
    others  = |(i_req & ~grant_q);

    unique case (state_q)
      IDLE, GAP: begin
        cnt_d = '0;
        if (pick_vld) begin
          state_d = SHOW;
          owner_d = pick_idx;
          grant_d = pick_gnt;
          show    = 1'b1;
          sel     = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (!i_req[owner_q] || ((cnt_q == CNT_MAX) && others)) begin
          state_d = GAP;
          cnt_d   = '0;
          ptr_d   = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          grant_d = grant_q;
          show    = 1'b1;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int k = 0; k < 8; k++) begin
      seg_d[k] = show ? hex2seg(i_data[32*int'(sel) + 4*k +: 4], i_dp[8*int'(sel) + k])
                      : SEG_BLANK;
    end
`ifdef SEG_SHARE_OWNER_ID_EN
    if (show) seg_d[7] = hex2seg(4'(sel), 1'b1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      for (int k = 0; k < 8; k++) seg_q[k] <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      for (int k = 0; k < 8; k++) seg_q[k] <= seg_d[k];
    end
  end

  assign o_grant = grant_q;
  assign o_seg0  = seg_q[0];
  assign o_seg1  = seg_q[1];
  assign o_seg2  = seg_q[2];
  assign o_seg3  = seg_q[3];
  assign o_seg4  = seg_q[4];
  assign o_seg5  = seg_q[5];
  assign o_seg6  = seg_q[6];
  assign o_seg7  = seg_q[7];

endmodule

// File: tb/tb_seg_share_ctrl.sv
// Directed bench for seg_share_ctrl with a cycle scoreboard fed by a behavioural model.
module tb_seg_share_ctrl;

  localparam int NREQ  = 3;
  localparam int SLICE = 4;

  localparam logic [6:0] TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  i_req;
  logic [95:0] i_data;
  logic [23:0] i_dp;
  logic [2:0]  o_grant;
  logic [7:0]  o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7;
  wire  [63:0] seg_bus = {o_seg7, o_seg6, o_seg5, o_seg4, o_seg3, o_seg2, o_seg1, o_seg0};

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  int m_state = 0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;

  logic [66:0] sb_q [$];

  always #5 clk = ~clk;

  seg_share_ctrl #(
    .NREQ         (NREQ),
    .SLICE_CYCLES (SLICE),
    .CNT_W        (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_data  (i_data),
    .i_dp    (i_dp),
    .o_grant (o_grant),
    .o_seg0  (o_seg0),
    .o_seg1  (o_seg1),
    .o_seg2  (o_seg2),
    .o_seg3  (o_seg3),
    .o_seg4  (o_seg4),
    .o_seg5  (o_seg5),
    .o_seg6  (o_seg6),
    .o_seg7  (o_seg7)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_segs(input int own);
    logic [63:0] s;
    logic [3:0]  nib;
    for (int k = 0; k < 8; k++) begin
      nib = i_data[32*own + 4*k +: 4];
      s[8*k +: 8] = ~{TAB[nib], i_dp[8*own + k]};
    end
`ifdef SEG_SHARE_OWNER_ID_EN
    s[63:56] = ~{TAB[own], 1'b1};
`endif
    return s;
  endfunction

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_push();
    logic [2:0]  g;
    logic [63:0] s;
    int          p;
    logic        oth;
    g = '0;
    s = '1;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_ptr = 0; m_owner = 0;
    end else if (m_state == 1) begin
      oth = (i_req & ~(3'b001 << m_owner)) != 3'b000;
      if (!i_req[m_owner] || (m_cnt == SLICE - 1 && oth)) begin
        m_state = 2;
        m_ptr   = (m_owner + 1) % NREQ;
      end else begin
        if (m_cnt < SLICE - 1) m_cnt++;
        g = 3'b001 << m_owner;
        s = model_segs(m_owner);
      end
    end else begin
      p = -1;
      for (int off = 0; off < NREQ; off++) begin
        if (p < 0 && i_req[(m_ptr + off) % NREQ]) p = (m_ptr + off) % NREQ;
      end
      if (p >= 0) begin
        m_state = 1; m_owner = p; m_cnt = 0;
        g = 3'b001 << p;
        s = model_segs(p);
      end else begin
        m_state = 0;
      end
    end
    sb_q.push_back({g, s});
  endtask

  task automatic tick();
    logic [66:0] e;
    model_push();
    @(posedge clk);
    #1;
    cyc_n++;
    e = sb_q.pop_front();
    check("sb_grant", 64'(o_grant), 64'(e[66:64]));
    check("sb_segs", seg_bus, e[63:0]);
  endtask

  initial begin
    int          first, second;
    logic        found;
    logic [2:0]  prev;

    rst    = 1'b1;
    i_req  = '0;
    i_data = {32'h01234567, 32'h89ABCDEF, 32'h76543210};
    i_dp   = '0;
    tick();
    tick();
    check("reset_grant", 64'(o_grant), 64'h0);
    check("reset_seg0", 64'(o_seg0), 64'hFF);

    rst = 1'b0;
    repeat (10) tick();
    check("idle_grant", 64'(o_grant), 64'h0);
    check("idle_segs", seg_bus, {64{1'b1}});

    // Sole requester 0
    i_req = 3'b001;
    tick();
    check("r0_grant", 64'(o_grant), 64'h1);
    check("r0_seg0", 64'(o_seg0), 64'h03);
`ifdef SEG_SHARE_OWNER_ID_EN
    check("r0_seg7", 64'(o_seg7), 64'h02);
`else
    check("r0_seg7", 64'(o_seg7), 64'h1F);
`endif
    repeat (22) tick();
    check("r0_hold", 64'(o_grant), 64'h1);
    repeat (16) begin
      i_data[31:0] = $urandom;
      i_dp[7:0]    = 8'($urandom);
      tick();
    end
    i_data[31:0] = 32'h76543210;
    i_dp         = '0;

    // Two contending requesters: period between owner-1 slices
    i_req = 3'b000;
    tick();
    tick();
    i_req  = 3'b011;
    first  = -1;
    second = -1;
    for (int n = 0; n < 30 && second < 0; n++) begin
      prev = o_grant;
      tick();
      if (o_grant == 3'b010 && prev != 3'b010) begin
        if (first < 0) first = cyc_n;
        else second = cyc_n;
      end
    end
    check("rr_period", 64'(second - first), 64'd10);

    // Owner 1 drops mid-slice while 0 and 2 wait
    i_req = 3'b111;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      prev = o_grant;
      tick();
      if (o_grant == 3'b010 && prev != 3'b010) found = 1'b1;
    end
    check("owner1_found", 64'(found), 64'h1);
    tick();
    check("owner1_cnt1", 64'(o_grant), 64'h2);
    i_req = 3'b101;
    tick();
    check("drop_gap", 64'(o_grant), 64'h0);
    tick();
    check("drop_next", 64'(o_grant), 64'h4);

    // Decimal point and live data reload on owner 2
    i_req         = 3'b100;
    i_data[67:64] = 4'hA;
    i_dp[23:16]   = 8'h01;
    tick();
    check("dp_seg0_A", 64'(o_seg0), 64'h10);
    i_data[67:64] = 4'hF;
    tick();
    check("dp_seg0_F", 64'(o_seg0), 64'h70);

    // Reset mid-slice, then slice restarts from zero
    i_req = 3'b010;
    tick();
    tick();
    check("r1_grant", 64'(o_grant), 64'h2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_grant", 64'(o_grant), 64'h0);
    check("mid_rst_segs", seg_bus, {64{1'b1}});
    rst = 1'b0;
    tick();
    check("post_rst_grant", 64'(o_grant), 64'h2);
    i_req = 3'b011;
    repeat (3) tick();
    check("slice_hold", 64'(o_grant), 64'h2);
    tick();
    check("slice_gap", 64'(o_grant), 64'h0);
    tick();
    check("slice_next", 64'(o_grant), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
